// File: rtl/prog_mem_pkg.sv
// Shared instruction-set definitions: word width, opcode field and NOP encoding,
// plus the loader state type used by the program memory.
package prog_mem_pkg;

    localparam int PM_DATA_WIDTH = 28;
    localparam int PM_OPCODE_W   = 6;

    localparam logic [PM_OPCODE_W-1:0] OP_NOP  = 6'h00;
    localparam logic [PM_OPCODE_W-1:0] OP_LOAD = 6'h01;
    localparam logic [PM_OPCODE_W-1:0] OP_STOR = 6'h02;
    localparam logic [PM_OPCODE_W-1:0] OP_JMP  = 6'h03;

    // All-zero word decodes as NOP; it is what the fetch port shows when idle.
    localparam logic [PM_DATA_WIDTH-1:0] PM_NOP = '0;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } ld_state_e;

    function automatic int bytes_per_word(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/prog_mem_loader.sv
// Byte-serial program download: assembles MSB-first bytes into words and emits one write per word.
// Write issued on the edge accepting the last byte of a word; oLoadByteReady-style ready only in LOAD.
module prog_mem_loader
    import prog_mem_pkg::*;
#(
    parameter int DATA_WIDTH = PM_DATA_WIDTH,
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  i_start,
    input  logic [16:0]           i_len,
    input  logic [7:0]            i_byte_dat,
    input  logic                  i_byte_vld,
    output logic                  o_byte_rdy,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_wr_en,
    output logic [ADDR_W-1:0]     o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_dat
);

    localparam int BPW   = bytes_per_word(DATA_WIDTH);
    localparam int SH_W  = BPW * 8;
    localparam int CNT_W = $clog2(BPW) + 1;
    localparam logic [16:0]      DEPTH_L   = 17'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BPW - 1);

    ld_state_e        r_state, w_next;
    logic [16:0]      r_ptr;
    logic [16:0]      r_len;
    logic [CNT_W-1:0] r_cnt;
    logic [SH_W-1:0]  r_shift;
    logic             r_err;
    logic             w_accept;
    logic             w_word_done;
    logic [SH_W-1:0]  w_assembled;

    assign w_accept    = (r_state == LD_LOAD) && i_byte_vld;
    assign w_word_done = w_accept && (r_cnt == LAST_BYTE);
    // Oldest byte falls off the top; bits above DATA_WIDTH never reach memory.
    assign w_assembled = SH_W'({r_shift, i_byte_dat});

    always_ff @(posedge Clock) begin
        if (Reset) r_state <= LD_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LD_IDLE: begin
                if (i_start) begin
                    if (i_len == 17'd0)        w_next = LD_DONE;
                    else if (i_len <= DEPTH_L) w_next = LD_LOAD;
                end
            end
            LD_LOAD: begin
                if (w_word_done && (r_ptr == r_len - 17'd1)) w_next = LD_DONE;
            end
            LD_DONE: w_next = LD_IDLE;
            default: w_next = LD_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_ptr   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= (r_state == LD_IDLE) && i_start && (i_len > DEPTH_L);
            if ((r_state == LD_IDLE) && i_start) begin
                r_ptr <= '0;
                r_cnt <= '0;
                r_len <= i_len;
            end else if (w_accept) begin
                r_shift <= w_assembled;
                if (w_word_done) begin
                    r_cnt <= '0;
                    r_ptr <= r_ptr + 17'd1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_byte_rdy = (r_state == LD_LOAD);
    assign o_busy     = (r_state != LD_IDLE);
    assign o_done     = (r_state == LD_DONE);
    assign o_err      = r_err;
    assign o_wr_en    = w_word_done && !Reset;
    assign o_wr_addr  = r_ptr[ADDR_W-1:0];
    assign o_wr_dat   = DATA_WIDTH'(w_assembled);

endmodule

// File: rtl/prog_mem.sv
// Instruction memory with 1-cycle registered fetch and a byte-serial download port.
// Fetch latency 1 cycle; fetches are dropped (not queued) while a download is busy.
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int                    DATA_WIDTH   = PM_DATA_WIDTH,
    parameter int                    DEPTH        = 256,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = DATA_WIDTH'(PM_NOP),
    parameter string                 INIT_FILE    = ""
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [15:0]           iAddress,
    input  logic                  iFetchEnable,
    output logic [DATA_WIDTH-1:0] oInstruction,
    output logic                  oInstructionValid,
    input  logic                  iLoadStart,
    input  logic [16:0]           iLoadLength,
    input  logic [7:0]            iLoadByte,
    input  logic                  iLoadByteValid,
    output logic                  oLoadByteReady,
    output logic                  oLoadBusy,
    output logic                  oLoadDone,
    output logic                  oLoadError
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_dat;
    logic                  r_vld;
    logic                  r_hit;
    logic                  w_busy;
    logic                  w_fetch;
    logic                  w_in_range;
    logic                  w_wr_en;
    logic [ADDR_W-1:0]     w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_dat;

    prog_mem_loader #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_loader (
        .Clock      (Clock),
        .Reset      (Reset),
        .i_start    (iLoadStart),
        .i_len      (iLoadLength),
        .i_byte_dat (iLoadByte),
        .i_byte_vld (iLoadByteValid),
        .o_byte_rdy (oLoadByteReady),
        .o_busy     (w_busy),
        .o_done     (oLoadDone),
        .o_err      (oLoadError),
        .o_wr_en    (w_wr_en),
        .o_wr_addr  (w_wr_addr),
        .o_wr_dat   (w_wr_dat)
    );

    assign w_fetch    = iFetchEnable && !w_busy;
    assign w_in_range = ({1'b0, iAddress} < 17'(DEPTH));

    // Plain write + read ports with no reset so the array maps onto block RAM.
    always_ff @(posedge Clock) begin
        if (w_wr_en) r_mem[w_wr_addr] <= w_wr_dat;
        if (w_fetch) r_rd_dat <= r_mem[iAddress[ADDR_W-1:0]];
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_vld <= 1'b0;
            r_hit <= 1'b0;
        end else begin
            r_vld <= w_fetch;
            r_hit <= w_fetch && w_in_range;
        end
    end

    assign oInstruction      = r_hit ? r_rd_dat : DEFAULT_WORD;
    assign oInstructionValid = r_vld;
    assign oLoadBusy         = w_busy;

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: fetch expectations queued at issue, checked by a negedge monitor.
module tb_prog_mem;

    localparam int DW    = 28;
    localparam int DEPTH = 256;

    logic          Clock = 1'b0;
    logic          Reset;
    logic [15:0]   iAddress;
    logic          iFetchEnable;
    logic [DW-1:0] oInstruction;
    logic          oInstructionValid;
    logic          iLoadStart;
    logic [16:0]   iLoadLength;
    logic [7:0]    iLoadByte;
    logic          iLoadByteValid;
    logic          oLoadByteReady;
    logic          oLoadBusy;
    logic          oLoadDone;
    logic          oLoadError;

    int            tests = 0;
    int            fails = 0;
    bit            mon_en = 1'b0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mdl[DEPTH];
    logic [7:0]    lbytes[$];

    prog_mem u_dut (
        .Clock             (Clock),
        .Reset             (Reset),
        .iAddress          (iAddress),
        .iFetchEnable      (iFetchEnable),
        .oInstruction      (oInstruction),
        .oInstructionValid (oInstructionValid),
        .iLoadStart        (iLoadStart),
        .iLoadLength       (iLoadLength),
        .iLoadByte         (iLoadByte),
        .iLoadByteValid    (iLoadByteValid),
        .oLoadByteReady    (oLoadByteReady),
        .oLoadBusy         (oLoadBusy),
        .oLoadDone         (oLoadDone),
        .oLoadError        (oLoadError)
    );

    always #5 Clock = ~Clock;

    task automatic checkb(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Scoreboard monitor: every valid fetch must match the oldest queued expectation.
    always @(negedge Clock) begin
        if (mon_en) begin
            if (oInstructionValid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: got data %h with nothing expected", oInstruction);
                end else begin
                    checkw("fetch_data", oInstruction, exp_q.pop_front());
                end
            end else begin
                checkw("idle_default", oInstruction, 28'h0);
            end
        end
    end

    task automatic fetch(input int addr, input logic [DW-1:0] exp);
        iFetchEnable = 1'b1;
        iAddress     = 16'(addr);
        exp_q.push_back(exp);
        step();
        iFetchEnable = 1'b0;
    endtask

    task automatic do_load(input int len, input bit fe, input bit gap);
        logic [31:0] w;
        iLoadStart  = 1'b1;
        iLoadLength = 17'(len);
        if (fe) begin
            iFetchEnable = 1'b1;
            iAddress     = 16'd0;
            exp_q.push_back(mdl[0]);
        end
        step();
        iLoadStart = 1'b0;
        if (len > DEPTH) begin
            checkb("err_pulse", oLoadError, 1'b1);
            checkb("err_busy", oLoadBusy, 1'b0);
            step();
            checkb("err_clear", oLoadError, 1'b0);
            checkb("err_busy2", oLoadBusy, 1'b0);
        end else if (len == 0) begin
            checkb("zero_done", oLoadDone, 1'b1);
            checkb("zero_busy", oLoadBusy, 1'b1);
            step();
            checkb("zero_done_clr", oLoadDone, 1'b0);
            checkb("zero_idle", oLoadBusy, 1'b0);
        end else begin
            for (int i = 0; i < len * 4; i++) begin
                checkb("byte_rdy", oLoadByteReady, 1'b1);
                checkb("load_busy", oLoadBusy, 1'b1);
                if (gap && i == 2) begin
                    iLoadByteValid = 1'b0;
                    iLoadStart     = 1'b1;
                    iLoadLength    = 17'd0;
                    step();
                    iLoadStart = 1'b0;
                    checkb("gap_rdy", oLoadByteReady, 1'b1);
                end
                iLoadByte      = lbytes[i];
                iLoadByteValid = 1'b1;
                step();
            end
            iLoadByteValid = 1'b0;
            checkb("done_pulse", oLoadDone, 1'b1);
            checkb("done_busy", oLoadBusy, 1'b1);
            checkb("done_rdy", oLoadByteReady, 1'b0);
            step();
            checkb("done_clear", oLoadDone, 1'b0);
            checkb("back_idle", oLoadBusy, 1'b0);
            for (int k = 0; k < len; k++) begin
                w = {lbytes[4*k], lbytes[4*k+1], lbytes[4*k+2], lbytes[4*k+3]};
                mdl[k] = w[DW-1:0];
            end
            if (fe) begin
                exp_q.push_back(mdl[0]);
                step();
            end
        end
        iFetchEnable = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; iAddress = '0; iFetchEnable = 1'b0; iLoadStart = 1'b0;
        iLoadLength = '0; iLoadByte = '0; iLoadByteValid = 1'b0;
        repeat (3) step();
        Reset = 1'b0;
        checkb("rst_valid", oInstructionValid, 1'b0);
        checkw("rst_instr", oInstruction, 28'h0);
        checkb("rst_busy", oLoadBusy, 1'b0);
        checkb("rst_done", oLoadDone, 1'b0);
        checkb("rst_err", oLoadError, 1'b0);
        checkb("rst_rdy", oLoadByteReady, 1'b0);
        mon_en = 1'b1;

        lbytes = '{8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'h0A, 8'hBC, 8'hDE, 8'hF0};
        do_load(2, 1'b0, 1'b0);
        fetch(0, 28'hFFFFFFF);
        fetch(1, 28'hABCDEF0);

        lbytes = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hF1, 8'h23, 8'h45, 8'h67,
                   8'h0C, 8'hAF, 8'hEB, 8'hAB};
        do_load(3, 1'b0, 1'b1);
        fetch(1, 28'h1234567);
        fetch(0, 28'h0000001);
        fetch(2, 28'hCAFEBAB);

        fetch(300, 28'h0);
        fetch(256, 28'h0);
        fetch(65535, 28'h0);
        fetch(2, 28'hCAFEBAB);

        do_load(257, 1'b0, 1'b0);
        fetch(0, 28'h0000001);
        fetch(1, 28'h1234567);

        do_load(0, 1'b0, 1'b0);
        fetch(0, 28'h0000001);

        lbytes = '{8'h01, 8'h11, 8'h11, 8'h11, 8'h02, 8'h22, 8'h22, 8'h22};
        do_load(2, 1'b1, 1'b0);
        fetch(0, 28'h1111111);

        iLoadByte = 8'hAA; iLoadByteValid = 1'b1;
        step(); step();
        iLoadByteValid = 1'b0;
        fetch(1, 28'h2222222);

        lbytes = '{8'h0A, 8'hAA, 8'hAA, 8'hAA, 8'h0B};
        iLoadStart = 1'b1; iLoadLength = 17'd3;
        step();
        iLoadStart = 1'b0;
        for (int i = 0; i < 5; i++) begin
            iLoadByte = lbytes[i]; iLoadByteValid = 1'b1;
            step();
        end
        iLoadByteValid = 1'b0;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checkb("abort_busy", oLoadBusy, 1'b0);
        checkb("abort_rdy", oLoadByteReady, 1'b0);
        checkb("abort_done", oLoadDone, 1'b0);
        checkb("abort_err", oLoadError, 1'b0);
        checkb("abort_valid", oInstructionValid, 1'b0);
        fetch(0, 28'hAAAAAAA);
        fetch(1, 28'h2222222);
        fetch(2, 28'hCAFEBAB);

        lbytes = '{8'h0D, 8'hDD, 8'hDD, 8'hDD};
        do_load(1, 1'b0, 1'b0);
        fetch(0, 28'hDDDDDDD);
        fetch(1, 28'h2222222);

        step(); step();
        mon_en = 1'b0;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d fetch results never appeared, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
